faux_sata_hd: RTL and testbench

FAUX_SATA_HD -- requirements
Module: faux_sata_hd

---
 rtl/sata_pkg.sv | 20 ++
 rtl/faux_sata_oob.sv | 77 +++++++
 rtl/faux_sata_hd.sv | 201 ++++++++++++++++++++
 tb/tb_faux_sata_hd.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sata_pkg.sv
// SATA link-layer primitive dwords shared by the faux drive and the host stack.
// K28.3/K28.5 sits in byte 0, so every primitive carries K flag 4'b0001.
package sata_pkg;

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_X_RDY = 32'h5757B57C;
  localparam logic [31:0] PRIM_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] PRIM_R_IP  = 32'h5555B57C;
  localparam logic [31:0] PRIM_R_OK  = 32'h3535B57C;
  localparam logic [31:0] PRIM_WTRM  = 32'h5858B57C;
  localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;

  localparam logic [3:0]  PRIM_ISK   = 4'b0001;

endpackage

// File: rtl/faux_sata_oob.sv
// Device side of the OOB handshake: COMRESET -> COMINIT -> COMWAKE.
// link_en rises once both device pulses have been sent.
module faux_sata_oob #(
  parameter int OOB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic comm_reset_detect,
  input  logic comm_wake_detect,
  output logic tx_comm_reset,
  output logic tx_comm_wake,
  output logic link_en
);

  localparam int CW = $clog2(OOB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(OOB_CYCLES - 1);

  localparam logic [2:0] S_WAIT_RST  = 3'd0;
  localparam logic [2:0] S_WAIT_END  = 3'd1;
  localparam logic [2:0] S_COMINIT   = 3'd2;
  localparam logic [2:0] S_WAIT_WAKE = 3'd3;
  localparam logic [2:0] S_COMWAKE   = 3'd4;
  localparam logic [2:0] S_LINK      = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;

  assign link_en = (state == S_LINK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_WAIT_RST;
      cnt           <= '0;
      tx_comm_reset <= 1'b0;
      tx_comm_wake  <= 1'b0;
    end else if (comm_reset_detect) begin
      // a host COMRESET restarts the handshake from any state
      state         <= S_WAIT_END;
      cnt           <= '0;
      tx_comm_reset <= 1'b0;
      tx_comm_wake  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_WAIT_END): begin
          state         <= S_COMINIT;
          cnt           <= '0;
          tx_comm_reset <= 1'b1;
        end
        (state == S_COMINIT): begin
          if (cnt == LAST) begin
            state         <= S_WAIT_WAKE;
            tx_comm_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        (state == S_WAIT_WAKE): begin
          if (comm_wake_detect) begin
            state        <= S_COMWAKE;
            cnt          <= '0;
            tx_comm_wake <= 1'b1;
          end
        end
        (state == S_COMWAKE): begin
          if (cnt == LAST) begin
            state        <= S_LINK;
            tx_comm_wake <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/faux_sata_hd.sv
// Minimal SATA drive model: OOB bring-up, ALIGN lock, and a receive-only
// link FSM that acknowledges host frames without checking payload or CRC.
import sata_pkg::*;

module faux_sata_hd #(
  parameter int OOB_CYCLES  = 16,
  parameter int ALIGN_MATCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] tx_dout,
  output logic [3:0]  tx_isk,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_isk,
  input  logic        rx_is_elec_idle,
  output logic        rx_byte_is_aligned,
  input  logic        comm_reset_detect,
  input  logic        comm_wake_detect,
  output logic        tx_comm_reset,
  output logic        tx_comm_wake,
  output logic        hd_ready,
  output logic [31:0] hd_data_to_host,
  input  logic        dbg_hold,
  input  logic        dbg_data_scrambler_en,
  input  logic        dbg_ll_write_start,
  input  logic [31:0] dbg_ll_write_data,
  input  logic [23:0] dbg_ll_write_size,
  input  logic        dbg_ll_write_hold,
  input  logic        dbg_ll_write_abort,
  input  logic        dbg_ll_read_ready,
  input  logic        dbg_t_en,
  input  logic        dbg_send_reg_stb,
  input  logic        dbg_send_dma_act_stb,
  input  logic        dbg_send_data_stb,
  input  logic        dbg_send_pio_stb,
  input  logic        dbg_send_dev_bits_stb,
  input  logic [15:0] dbg_pio_transfer_count,
  input  logic        dbg_pio_direction,
  input  logic [7:0]  dbg_pio_e_status,
  input  logic        dbg_d2h_interrupt,
  input  logic        dbg_d2h_notification,
  input  logic [7:0]  dbg_d2h_status,
  input  logic [7:0]  dbg_d2h_error,
  input  logic [3:0]  dbg_d2h_port_mult,
  input  logic [7:0]  dbg_d2h_device,
  input  logic [47:0] dbg_d2h_lba,
  input  logic [15:0] dbg_d2h_sector_count,
  input  logic [31:0] dbg_cl_if_data,
  input  logic        dbg_cl_if_ready,
  input  logic [23:0] dbg_cl_if_size,
  input  logic [1:0]  dbg_cl_of_ready,
  input  logic [23:0] dbg_cl_of_size
);

  localparam int ACW = $clog2(ALIGN_MATCH + 1);
  localparam logic [ACW-1:0] A_LAST = ACW'(ALIGN_MATCH - 1);

  localparam logic [2:0] L_ALIGN = 3'd0;
  localparam logic [2:0] L_IDLE  = 3'd1;
  localparam logic [2:0] L_RDY   = 3'd2;
  localparam logic [2:0] L_DATA  = 3'd3;
  localparam logic [2:0] L_END   = 3'd4;

  logic           link_en, live;
  logic [2:0]     lstate, nstate;
  logic [ACW-1:0] acnt, ncnt;
  logic [31:0]    last_prim, eff, ntx;
  logic           cont_act, eff_prim, rx_prim, rx_cont;
  logic           h_xrdy, h_sof, h_eof, h_sync, h_hold;

  logic unused_dbg;
  assign unused_dbg = ^{dbg_data_scrambler_en, dbg_ll_write_start,
    dbg_ll_write_data, dbg_ll_write_size, dbg_ll_write_hold,
    dbg_ll_write_abort, dbg_ll_read_ready, dbg_t_en,
    dbg_send_reg_stb, dbg_send_dma_act_stb, dbg_send_data_stb,
    dbg_send_pio_stb, dbg_send_dev_bits_stb,
    dbg_pio_transfer_count, dbg_pio_direction, dbg_pio_e_status,
    dbg_d2h_interrupt, dbg_d2h_notification, dbg_d2h_status,
    dbg_d2h_error, dbg_d2h_port_mult, dbg_d2h_device, dbg_d2h_lba,
    dbg_d2h_sector_count, dbg_cl_if_data, dbg_cl_if_ready,
    dbg_cl_if_size, dbg_cl_of_ready, dbg_cl_of_size};

  faux_sata_oob #(
    .OOB_CYCLES(OOB_CYCLES)
  ) u_oob (
    .clk              (clk),
    .rst              (rst),
    .comm_reset_detect(comm_reset_detect),
    .comm_wake_detect (comm_wake_detect),
    .tx_comm_reset    (tx_comm_reset),
    .tx_comm_wake     (tx_comm_wake),
    .link_en          (link_en)
  );

  assign live    = link_en && !comm_reset_detect;
  assign rx_prim = |rx_isk;
  assign rx_cont = rx_prim && (rx_din == PRIM_CONT);

  // CONT, and scrambled filler following it, read as the last primitive
  always_comb begin
    eff      = rx_din;
    eff_prim = rx_prim;
    if (rx_cont || (!rx_prim && cont_act)) begin
      eff      = last_prim;
      eff_prim = 1'b1;
    end
  end

  assign h_xrdy = !rx_is_elec_idle && eff_prim && (eff == PRIM_X_RDY);
  assign h_sof  = !rx_is_elec_idle && eff_prim && (eff == PRIM_SOF);
  assign h_eof  = !rx_is_elec_idle && eff_prim && (eff == PRIM_EOF);
  assign h_sync = !rx_is_elec_idle && eff_prim && (eff == PRIM_SYNC);
  assign h_hold = !rx_is_elec_idle && eff_prim && (eff == PRIM_HOLD);

  always_comb begin
    nstate = lstate;
    ncnt   = acnt;
    if (!rx_is_elec_idle) begin
      unique case (1'b1)
        (lstate == L_ALIGN): begin
          if (rx_din == PRIM_ALIGN) begin
            if (acnt == A_LAST) begin
              nstate = L_IDLE;
              ncnt   = '0;
            end else begin
              ncnt = acnt + 1'b1;
            end
          end else begin
            ncnt = '0;
          end
        end
        (lstate == L_IDLE): if (h_xrdy) nstate = L_IDLE + 3'd1;
        (lstate == L_RDY): begin
          if (h_sof)       nstate = L_DATA;
          else if (h_sync) nstate = L_IDLE;
        end
        (lstate == L_DATA): begin
          if (h_eof)       nstate = L_END;
          else if (h_sync) nstate = L_IDLE;
        end
        (lstate == L_END): if (h_sync) nstate = L_IDLE;
        default: nstate = L_ALIGN;
      endcase
    end
  end

  always_comb begin
    ntx = PRIM_ALIGN;
    unique case (1'b1)
      (nstate == L_IDLE): ntx = PRIM_SYNC;
      (nstate == L_RDY):  ntx = PRIM_R_RDY;
      (nstate == L_DATA): begin
        if (h_hold && lstate == L_DATA) ntx = PRIM_HOLDA;
        else if (dbg_hold)              ntx = PRIM_HOLD;
        else                            ntx = PRIM_R_IP;
      end
      (nstate == L_END):  ntx = PRIM_R_OK;
      default:            ntx = PRIM_ALIGN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lstate             <= L_ALIGN;
      acnt               <= '0;
      last_prim          <= PRIM_ALIGN;
      cont_act           <= 1'b0;
      tx_dout            <= PRIM_ALIGN;
      tx_isk             <= PRIM_ISK;
      rx_byte_is_aligned <= 1'b0;
      hd_ready           <= 1'b0;
      hd_data_to_host    <= '0;
    end else begin
      hd_data_to_host <= tx_dout;
      tx_isk          <= PRIM_ISK;
      if (!live) begin
        lstate             <= L_ALIGN;
        acnt               <= '0;
        cont_act           <= 1'b0;
        tx_dout            <= PRIM_ALIGN;
        rx_byte_is_aligned <= 1'b0;
        hd_ready           <= 1'b0;
      end else begin
        lstate             <= nstate;
        acnt               <= ncnt;
        tx_dout            <= ntx;
        rx_byte_is_aligned <= (nstate != L_ALIGN);
        hd_ready           <= (nstate == L_IDLE);
        if (!rx_is_elec_idle && rx_prim) begin
          if (rx_cont) begin
            cont_act <= 1'b1;
          end else begin
            cont_act  <= 1'b0;
            last_prim <= rx_din;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_faux_sata_hd.sv
// Randomised scoreboard bench for faux_sata_hd: a protocol-level model
// predicts each device dword; separate monitors check link and OOB output.
module tb_faux_sata_hd;
  import sata_pkg::*;

  localparam int OOB_N   = 16;
  localparam int ALIGN_N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tx_dout, rx_din, hd_data_to_host;
  logic [3:0]  tx_isk, rx_isk;
  logic        rx_is_elec_idle, rx_byte_is_aligned;
  logic        comm_reset_detect, comm_wake_detect;
  logic        tx_comm_reset, tx_comm_wake, hd_ready;
  logic        dbg_hold;

  always #5 clk = ~clk;

  faux_sata_hd #(.OOB_CYCLES(OOB_N), .ALIGN_MATCH(ALIGN_N)) dut (
    .clk(clk), .rst(rst),
    .tx_dout(tx_dout), .tx_isk(tx_isk),
    .rx_din(rx_din), .rx_isk(rx_isk),
    .rx_is_elec_idle(rx_is_elec_idle),
    .rx_byte_is_aligned(rx_byte_is_aligned),
    .comm_reset_detect(comm_reset_detect),
    .comm_wake_detect(comm_wake_detect),
    .tx_comm_reset(tx_comm_reset), .tx_comm_wake(tx_comm_wake),
    .hd_ready(hd_ready), .hd_data_to_host(hd_data_to_host),
    .dbg_hold(dbg_hold), .dbg_data_scrambler_en(1'b0),
    .dbg_ll_write_start(1'b0), .dbg_ll_write_data(32'h0),
    .dbg_ll_write_size(24'h0), .dbg_ll_write_hold(1'b0),
    .dbg_ll_write_abort(1'b0), .dbg_ll_read_ready(1'b0),
    .dbg_t_en(1'b0), .dbg_send_reg_stb(1'b0),
    .dbg_send_dma_act_stb(1'b0), .dbg_send_data_stb(1'b0),
    .dbg_send_pio_stb(1'b0), .dbg_send_dev_bits_stb(1'b0),
    .dbg_pio_transfer_count(16'h0), .dbg_pio_direction(1'b0),
    .dbg_pio_e_status(8'h0), .dbg_d2h_interrupt(1'b0),
    .dbg_d2h_notification(1'b0), .dbg_d2h_status(8'h0),
    .dbg_d2h_error(8'h0), .dbg_d2h_port_mult(4'h0),
    .dbg_d2h_device(8'h0), .dbg_d2h_lba(48'h0),
    .dbg_d2h_sector_count(16'h0), .dbg_cl_if_data(32'h0),
    .dbg_cl_if_ready(1'b0), .dbg_cl_if_size(24'h0),
    .dbg_cl_of_ready(2'b0), .dbg_cl_of_size(24'h0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (bound expired or leftover expectations)", name);
  endtask

  typedef struct packed {
    logic [31:0] tx;
    logic        rdy;
    logic        al;
  } exp_t;

  exp_t exp_q[$];
  int   cr_q[$];
  int   cw_q[$];

  // Protocol-level reference: where the device is in a host frame
  typedef enum int {M_ALIGN, M_IDLE, M_RDY, M_DATA, M_END} mph_t;
  mph_t        ph = M_ALIGN;
  int          align_seen = 0;
  bit          cont_m = 0;
  logic [31:0] last_m = PRIM_ALIGN;

  function automatic exp_t model_step();
    exp_t        r;
    logic [31:0] e;
    bit          ep, holda;
    holda = 0;
    if (comm_reset_detect) begin
      ph = M_ALIGN;
      align_seen = 0;
      cont_m = 0;
    end else if (!rx_is_elec_idle) begin
      if (rx_isk != 0 && rx_din == PRIM_CONT) begin
        cont_m = 1; e = last_m; ep = 1;
      end else if (rx_isk != 0) begin
        cont_m = 0; last_m = rx_din; e = rx_din; ep = 1;
      end else begin
        e = cont_m ? last_m : rx_din; ep = cont_m;
      end
      holda = (ph == M_DATA) && ep && (e == PRIM_HOLD);
      case (ph)
        M_ALIGN: begin
          if (rx_din == PRIM_ALIGN) align_seen++;
          else align_seen = 0;
          if (align_seen == ALIGN_N) ph = M_IDLE;
        end
        M_IDLE: if (ep && e == PRIM_X_RDY) ph = M_RDY;
        M_RDY: begin
          if (ep && e == PRIM_SOF) ph = M_DATA;
          else if (ep && e == PRIM_SYNC) ph = M_IDLE;
        end
        M_DATA: begin
          if (ep && e == PRIM_EOF) ph = M_END;
          else if (ep && e == PRIM_SYNC) ph = M_IDLE;
        end
        M_END: if (ep && e == PRIM_SYNC) ph = M_IDLE;
        default: ;
      endcase
    end
    case (ph)
      M_IDLE:  r.tx = PRIM_SYNC;
      M_RDY:   r.tx = PRIM_R_RDY;
      M_DATA:  r.tx = holda ? PRIM_HOLDA :
                      (dbg_hold ? PRIM_HOLD : PRIM_R_IP);
      M_END:   r.tx = PRIM_R_OK;
      default: r.tx = PRIM_ALIGN;
    endcase
    r.rdy = (ph == M_IDLE);
    r.al  = (ph != M_ALIGN);
    return r;
  endfunction

  // Link monitor: one expectation per clocked host dword
  logic [31:0] prev_tx = PRIM_ALIGN;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      check("tx_dout", {32'h0, tx_dout}, {32'h0, x.tx});
      check("tx_isk", {60'h0, tx_isk}, {60'h0, PRIM_ISK});
      check("hd_ready", {63'h0, hd_ready}, {63'h0, x.rdy});
      check("aligned", {63'h0, rx_byte_is_aligned}, {63'h0, x.al});
      check("hd_data_to_host", {32'h0, hd_data_to_host},
            {32'h0, prev_tx});
      prev_tx = x.tx;
    end
  end

  // OOB monitor: measures each device pulse width
  int  cr_len = 0, cw_len = 0;
  bit  cr_prev = 0, cw_prev = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (tx_comm_reset) cr_len++;
      if (cr_prev && !tx_comm_reset) begin
        if (cr_q.size() > 0) check("cominit_len", 64'(cr_len),
                                   64'(cr_q.pop_front()));
        else fail_now("cominit_unexpected");
        cr_len = 0;
      end
      if (tx_comm_wake) cw_len++;
      if (cw_prev && !tx_comm_wake) begin
        if (cw_q.size() > 0) check("comwake_len", 64'(cw_len),
                                   64'(cw_q.pop_front()));
        else fail_now("comwake_unexpected");
        cw_len = 0;
      end
      cr_prev = tx_comm_reset;
      cw_prev = tx_comm_wake;
    end
  end

  bit want_hold = 0;
  bit want_crd  = 0;

  task automatic send(input logic [31:0] d, input logic [3:0] k,
                      input bit idl);
    @(negedge clk);
    rx_din            = d;
    rx_isk            = k;
    rx_is_elec_idle   = idl;
    dbg_hold          = want_hold;
    comm_reset_detect = want_crd;
    @(posedge clk);
    exp_q.push_back(model_step());
  endtask

  task automatic prim(input logic [31:0] p);
    send(p, PRIM_ISK, 1'b0);
  endtask

  task automatic data(input logic [31:0] d);
    send(d, 4'b0000, 1'b0);
  endtask

  task automatic do_oob();
    int n;
    @(negedge clk);
    rx_is_elec_idle   = 1'b1;
    dbg_hold          = 1'b0;
    comm_reset_detect = 1'b1;
    cr_q.push_back(OOB_N);
    repeat (10) @(negedge clk);
    comm_reset_detect = 1'b0;
    want_crd = 0;
    n = 0;
    while (!tx_comm_reset && n < 200) begin @(negedge clk); n++; end
    while (tx_comm_reset && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail_now("cominit_wait");
    repeat (3) @(negedge clk);
    comm_wake_detect = 1'b1;
    cw_q.push_back(OOB_N);
    @(negedge clk);
    comm_wake_detect = 1'b0;
    n = 0;
    while (!tx_comm_wake && n < 200) begin @(negedge clk); n++; end
    while (tx_comm_wake && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) fail_now("comwake_wait");
    check("oob_tx_align", {32'h0, tx_dout}, {32'h0, PRIM_ALIGN});
    check("oob_not_ready", {63'h0, hd_ready}, 64'h0);
  endtask

  task automatic align_seq();
    repeat (3) prim(PRIM_ALIGN);
    prim(PRIM_SYNC);
    repeat (4) prim(PRIM_ALIGN);
  endtask

  task automatic frame();
    prim(PRIM_X_RDY);
    prim(PRIM_SOF);
    repeat (3) data($urandom);
    prim(PRIM_EOF);
    prim(PRIM_WTRM);
    prim(PRIM_SYNC);
  endtask

  logic [31:0] plist [0:7];

  initial begin
    plist[0] = PRIM_X_RDY; plist[1] = PRIM_SOF;
    plist[2] = PRIM_EOF;   plist[3] = PRIM_SYNC;
    plist[4] = PRIM_HOLD;  plist[5] = PRIM_WTRM;
    plist[6] = PRIM_CONT;  plist[7] = PRIM_R_IP;
    rst = 1'b0;
    rx_din = 32'h0; rx_isk = 4'h0; rx_is_elec_idle = 1'b1;
    comm_reset_detect = 1'b0; comm_wake_detect = 1'b0;
    dbg_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_dout", {32'h0, tx_dout}, {32'h0, PRIM_ALIGN});
    check("rst_tx_isk", {60'h0, tx_isk}, {60'h0, PRIM_ISK});
    check("rst_comm_reset", {63'h0, tx_comm_reset}, 64'h0);
    check("rst_comm_wake", {63'h0, tx_comm_wake}, 64'h0);
    check("rst_aligned", {63'h0, rx_byte_is_aligned}, 64'h0);
    check("rst_hd_ready", {63'h0, hd_ready}, 64'h0);
    check("rst_hd_data", {32'h0, hd_data_to_host}, 64'h0);
    rst = 1'b1;

    do_oob();
    align_seq();
    frame();

    prim(PRIM_X_RDY);
    prim(PRIM_SOF);
    data($urandom);
    want_hold = 1;
    data($urandom);
    data($urandom);
    want_hold = 0;
    prim(PRIM_HOLD);
    prim(PRIM_HOLD);
    data($urandom);
    prim(PRIM_EOF);
    prim(PRIM_SYNC);

    for (int i = 0; i < 300; i++) begin
      int r;
      bit idl;
      want_hold = ($urandom_range(0, 3) == 0);
      idl = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 11);
      if (r < 8) send(plist[r], PRIM_ISK, idl);
      else send($urandom, 4'b0000, idl);
    end
    want_hold = 0;
    prim(PRIM_SYNC);
    prim(PRIM_SYNC);

    prim(PRIM_X_RDY);
    prim(PRIM_SOF);
    data($urandom);
    want_crd = 1;
    data($urandom);
    data($urandom);
    do_oob();
    align_seq();
    frame();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0 || cr_q.size() != 0 || cw_q.size() != 0)
      fail_now("drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
